// File: rtl/cruise_speed_sequencer.sv
// Cruise speed sequencer: forwards pedals in manual mode, steps the speed FSM
// one level at a time toward a latched target in cruise mode, and flags faults.
module cruise_speed_sequencer #(
  parameter int unsigned DWELL_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       keys,
  input  logic       driver_brake,
  input  logic       driver_accel,
  input  logic       cruise_set,
  input  logic       cruise_cancel,
  input  logic [1:0] target_speed,
  input  logic [1:0] speed_fb,
  output logic       brake,
  output logic       accelerate,
  output logic       cruise_active,
  output logic       fault
);

  typedef enum logic [2:0] {
    IDLE,
    ENGAGED,
    STEP,
    WAIT_FB,
    DWELL,
    FAULT
  } state_t;

  localparam logic [7:0] DWELL_LAST   = 8'(DWELL_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [1:0] target_q, target_d;
  logic [1:0] start_q, start_d;
  logic       up_q, up_d;
  logic       brake_q, brake_d;
  logic       accel_q, accel_d;
  logic       cruising;
  logic [1:0] expected_fb;

  assign cruising    = (state_q == ENGAGED) || (state_q == STEP) ||
                       (state_q == WAIT_FB) || (state_q == DWELL);
  // Speed the FSM should report once the last commanded step has landed.
  assign expected_fb = up_q ? (start_q + 2'd1) : (start_q - 2'd1);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    start_d  = start_q;
    up_d     = up_q;
    brake_d  = 1'b0;
    accel_d  = 1'b0;

    if (!keys) begin
      state_d = IDLE;
      count_d = 8'd0;
    end else if (cruising && (driver_brake || cruise_cancel)) begin
      state_d = IDLE;
      count_d = 8'd0;
      brake_d = driver_brake;
    end else begin
      if (cruising && cruise_set && (target_speed != 2'b00)) begin
        target_d = target_speed;
      end
      unique case (state_q)
        IDLE: begin
          brake_d = driver_brake;
          accel_d = driver_accel & ~driver_brake;
          if (cruise_set && !driver_brake && (speed_fb != 2'b00) &&
              (target_speed != 2'b00)) begin
            target_d = target_speed;
            state_d  = ENGAGED;
          end
        end
        // The step command is registered here so it is high during STEP.
        ENGAGED: begin
          if (speed_fb != target_q) begin
            up_d    = (speed_fb < target_q);
            start_d = speed_fb;
            accel_d = (speed_fb < target_q);
            brake_d = (speed_fb > target_q);
            state_d = STEP;
          end
        end
        STEP: begin
          state_d = WAIT_FB;
          count_d = 8'd0;
        end
        WAIT_FB: begin
          if (speed_fb == expected_fb) begin
            state_d = DWELL;
            count_d = 8'd0;
          end else if ((speed_fb != start_q) || (count_q == TIMEOUT_LAST)) begin
            state_d = FAULT;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        DWELL: begin
          if (speed_fb != expected_fb) begin
            state_d = FAULT;
          end else if (count_q == DWELL_LAST) begin
            state_d = ENGAGED;
            count_d = 8'd0;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        FAULT: begin
          if (cruise_cancel) begin
            state_d = IDLE;
            count_d = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= 8'd0;
      target_q <= 2'b00;
      start_q  <= 2'b00;
      up_q     <= 1'b0;
      brake_q  <= 1'b0;
      accel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      start_q  <= start_d;
      up_q     <= up_d;
      brake_q  <= brake_d;
      accel_q  <= accel_d;
    end
  end

  assign brake         = brake_q;
  assign accelerate    = accel_q;
  assign cruise_active = cruising;
  assign fault         = (state_q == FAULT);

endmodule

// File: tb/tb_cruise_speed_sequencer.sv
// Bench for cruise_speed_sequencer: directed scenarios plus random pedal traffic,
// checked every cycle against a mode/age based reference model and a speed plant.
module tb_cruise_speed_sequencer;

  localparam int DWELL   = 4;
  localparam int TIMEOUT = 8;
  localparam int MANUAL  = 0;
  localparam int CRUISE  = 1;
  localparam int FAULTED = 2;

  logic       clock;
  logic       reset;
  logic       keys;
  logic       driver_brake;
  logic       driver_accel;
  logic       cruise_set;
  logic       cruise_cancel;
  logic [1:0] target_speed;
  logic [1:0] speed_fb;
  logic       brake;
  logic       accelerate;
  logic       cruise_active;
  logic       fault;

  int vectors = 0;
  int miscompares = 0;

  int mMode = MANUAL;
  int mTarget = 0;
  int mFrom = 0;
  bit mUp = 1'b0;
  int mAge = -1;
  int mMovedAt = 0;
  bit mBrake = 1'b0;
  bit mAccel = 1'b0;

  int plantSpeed = 0;
  bit plantResponsive = 1'b1;

  int cycleNo = 0;
  int accelPulses = 0;
  int brakePulses = 0;
  int lastAccelCycle = 0;
  int accelGap = 0;

  cruise_speed_sequencer #(.DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .keys         (keys),
    .driver_brake (driver_brake),
    .driver_accel (driver_accel),
    .cruise_set   (cruise_set),
    .cruise_cancel(cruise_cancel),
    .target_speed (target_speed),
    .speed_fb     (speed_fb),
    .brake        (brake),
    .accelerate   (accelerate),
    .cruise_active(cruise_active),
    .fault        (fault)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleNo, actual, expected);
    end
  endtask

  // Reference model: manual / cruise / faulted modes; in cruise, mAge is the
  // age since the last step command (-1 while waiting to evaluate the target).
  task automatic modelStep(input bit rst, input bit k, input bit db, input bit da,
                           input bit cs, input bit cc, input int ts, input int fb);
    int wantFb;
    int newT;
    if (rst) begin
      mMode = MANUAL; mTarget = 0; mBrake = 0; mAccel = 0; mAge = -1; mMovedAt = 0;
    end else if (!k) begin
      mMode = MANUAL; mBrake = 0; mAccel = 0;
    end else if (mMode == CRUISE && (db || cc)) begin
      mMode = MANUAL; mBrake = db; mAccel = 0;
    end else if (mMode == MANUAL) begin
      mBrake = db;
      mAccel = da && !db;
      if (cs && !db && fb != 0 && ts != 0) begin
        mMode = CRUISE; mTarget = ts; mAge = -1;
      end
    end else if (mMode == FAULTED) begin
      mBrake = 0; mAccel = 0;
      if (cc) mMode = MANUAL;
    end else begin
      mBrake = 0; mAccel = 0;
      newT = (cs && ts != 0) ? ts : mTarget;
      wantFb = mUp ? mFrom + 1 : mFrom - 1;
      if (mAge < 0) begin
        if (fb != mTarget) begin
          mUp = (fb < mTarget); mFrom = fb; mAge = 0; mMovedAt = 0;
          mAccel = mUp; mBrake = !mUp;
        end
      end else if (mAge == 0) begin
        mAge = 1;
      end else if (mMovedAt == 0) begin
        if (fb == wantFb) begin
          mMovedAt = mAge; mAge++;
        end else if (fb != mFrom || mAge == TIMEOUT) begin
          mMode = FAULTED;
        end else begin
          mAge++;
        end
      end else begin
        if (fb != wantFb) mMode = FAULTED;
        else if (mAge - mMovedAt == DWELL) mAge = -1;
        else mAge++;
      end
      mTarget = newT;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit k, input bit db, input bit da,
                               input bit cs, input bit cc, input int ts);
    int fb;
    fb = plantSpeed;
    reset = rst; keys = k; driver_brake = db; driver_accel = da;
    cruise_set = cs; cruise_cancel = cc; target_speed = 2'(ts); speed_fb = 2'(fb);
    @(posedge clock);
    if (plantResponsive) begin
      if (mBrake && plantSpeed > 0) plantSpeed--;
      else if (mAccel && plantSpeed < 3) plantSpeed++;
    end
    modelStep(rst, k, db, da, cs, cc, ts, fb);
    #1;
    cycleNo++;
    checkOutput("brake", int'(brake), int'(mBrake));
    checkOutput("accelerate", int'(accelerate), int'(mAccel));
    checkOutput("cruise_active", int'(cruise_active), int'(mMode == CRUISE));
    checkOutput("fault", int'(fault), int'(mMode == FAULTED));
    checkOutput("exclusive_cmd", int'(brake & accelerate), 0);
    if (accelerate === 1'b1) begin
      accelGap = cycleNo - lastAccelCycle;
      lastAccelCycle = cycleNo;
      accelPulses++;
    end
    if (brake === 1'b1) brakePulses++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    plantResponsive = 1'b1;
    plantSpeed = 1;
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("reset_outputs", int'({brake, accelerate, cruise_active, fault}), 0);
    idleCycles(2);
    plantResponsive = 1'b0;
    applyStimulus(0, 1, 0, 1, 0, 0, 0);
    checkOutput("accel_passthrough", int'(accelerate), 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    checkOutput("accel_one_cycle", int'(accelerate), 0);
    applyStimulus(0, 1, 1, 1, 0, 0, 0);
    checkOutput("brake_wins", int'({brake, accelerate}), 2);
    idleCycles(1);

    plantResponsive = 1'b1;
    plantSpeed = 1;
    accelPulses = 0;
    applyStimulus(0, 1, 0, 0, 1, 0, 3);
    idleCycles(25);
    checkOutput("up_pulse_count", accelPulses, 2);
    checkOutput("up_pulse_gap", accelGap, 3 + DWELL);
    checkOutput("up_final_speed", plantSpeed, 3);
    checkOutput("up_still_active", int'(cruise_active), 1);

    brakePulses = 0;
    applyStimulus(0, 1, 0, 0, 1, 0, 1);
    idleCycles(25);
    checkOutput("down_pulse_count", brakePulses, 2);
    checkOutput("down_final_speed", plantSpeed, 1);
    checkOutput("down_no_fault", int'(fault), 0);
    applyStimulus(0, 1, 0, 0, 0, 1, 0);

    plantResponsive = 1'b0;
    plantSpeed = 1;
    applyStimulus(0, 1, 0, 0, 1, 0, 2);
    idleCycles(1 + 1 + TIMEOUT);
    checkOutput("timeout_fault", int'({brake, accelerate, cruise_active, fault}), 1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("fault_holds_on_brake", int'(fault), 1);
    applyStimulus(0, 1, 0, 0, 0, 1, 0);
    checkOutput("cancel_clears_fault", int'({cruise_active, fault}), 0);

    applyStimulus(0, 1, 0, 0, 1, 0, 2);
    idleCycles(4);
    checkOutput("wait_fb_active", int'(cruise_active), 1);
    applyStimulus(0, 1, 1, 0, 0, 0, 0);
    checkOutput("wait_brake_exit", int'({cruise_active, brake}), 1);
    applyStimulus(0, 1, 0, 0, 1, 0, 2);
    idleCycles(4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("keys_off_exit", int'({brake, accelerate, cruise_active, fault}), 0);

    plantSpeed = 0;
    applyStimulus(0, 1, 0, 0, 1, 0, 3);
    checkOutput("reject_stop_speed", int'(cruise_active), 0);
    plantSpeed = 1;
    applyStimulus(0, 1, 0, 0, 1, 0, 0);
    checkOutput("reject_stop_target", int'(cruise_active), 0);

    plantResponsive = 1'b1;
    applyStimulus(0, 1, 0, 0, 1, 0, 3);
    idleCycles(4);
    checkOutput("dwell_active", int'(cruise_active), 1);
    applyStimulus(1, 1, 0, 0, 0, 0, 0);
    checkOutput("reset_in_dwell", int'({brake, accelerate, cruise_active, fault}), 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99) == 0) plantResponsive = ~plantResponsive;
      if ($urandom_range(199) == 0) plantSpeed = int'($urandom_range(3));
      applyStimulus($urandom_range(249) == 0, $urandom_range(59) != 0,
                    $urandom_range(24) == 0, $urandom_range(2) == 0,
                    $urandom_range(7) == 0, $urandom_range(59) == 0,
                    int'($urandom_range(3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
